ai_paddle: RTL



---
 rtl/ai_paddle.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ai_paddle.sv
// Computer-controlled left paddle: holds for REACT_FRAMES after the ball turns toward it, then tracks ball Y.
// Build option AI_MISS_EN adds an LFSR aim error latched on each entry into tracking.
module ai_paddle #(
    parameter int SCREEN_H     = 480,
    parameter int SPEED        = 4,
    parameter int DEADBAND     = 2,
    parameter int REACT_FRAMES = 6,
    parameter int HOME_Y       = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic [5:0] ball_width,
    input  logic       ball_direction,
    input  logic [5:0] wall_width,
    input  logic [8:0] paddle_length,
    output logic [8:0] paddle_y,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        CENTER = 2'd0,
        REACT  = 2'd1,
        TRACK  = 2'd2
    } state_t;

    localparam int CNT_W = (REACT_FRAMES < 2) ? 1 : $clog2(REACT_FRAMES);
    localparam logic [CNT_W-1:0] REACT_LOAD = CNT_W'((REACT_FRAMES > 0) ? REACT_FRAMES - 1 : 0);
    localparam logic signed [10:0] SCREEN_S   = 11'(SCREEN_H);
    localparam logic signed [10:0] SPEED_S    = 11'(SPEED);
    localparam logic signed [10:0] DEADBAND_S = 11'(DEADBAND);
    localparam logic signed [10:0] HOME_S     = 11'(HOME_Y);

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [8:0]         paddle_y_nxt;
    logic               latch_off;
    logic               tick_en;
    logic signed [10:0] offset;
    logic signed [10:0] lo_lim, hi_raw, hi_lim;
    logic signed [10:0] track_raw, target, moved;
    logic               unused_bits;

    function automatic logic signed [10:0] clamp(
        input logic signed [10:0] v,
        input logic signed [10:0] lo,
        input logic signed [10:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Moves by at most SPEED and never past the target; small errors are ignored.
    function automatic logic signed [10:0] step_toward(
        input logic signed [10:0] cur,
        input logic signed [10:0] tgt
    );
        logic signed [10:0] diff;
        logic signed [10:0] mag;
        logic signed [10:0] step;
        diff = tgt - cur;
        mag  = (diff < 0) ? -diff : diff;
        step = (mag > SPEED_S) ? SPEED_S : mag;
        if (mag <= DEADBAND_S) return cur;
        return (diff < 0) ? cur - step : cur + step;
    endfunction

    assign tick_en = frame_tick & enable;

    // A degenerate playfield (paddle taller than the gap) collapses onto the top limit.
    assign lo_lim = $signed({5'b0, wall_width});
    assign hi_raw = SCREEN_S - $signed({5'b0, wall_width}) - $signed({2'b0, paddle_length});
    assign hi_lim = (hi_raw < lo_lim) ? lo_lim : hi_raw;

    assign track_raw = $signed({2'b0, ball_y}) + $signed({6'b0, ball_width[5:1]})
                     - $signed({3'b0, paddle_length[8:1]}) + offset;
    assign target    = clamp((state_q == TRACK) ? track_raw : HOME_S, lo_lim, hi_lim);
    assign moved     = clamp(step_toward($signed({2'b0, paddle_y}), target), lo_lim, hi_lim);

    assign unused_bits = ^{ball_x, moved[10:9]};

    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        paddle_y_nxt = paddle_y;
        latch_off    = 1'b0;
        if (tick_en) begin
            case (state_q)
                CENTER: begin
                    if (ball_direction) begin
                        if (REACT_FRAMES == 0) begin
                            state_nxt = TRACK;
                            latch_off = 1'b1;
                        end else begin
                            state_nxt = REACT;
                            cnt_nxt   = REACT_LOAD;
                        end
                    end else begin
                        paddle_y_nxt = moved[8:0];
                    end
                end
                REACT: begin
                    if (!ball_direction) begin
                        state_nxt = CENTER;
                    end else if (cnt_q == '0) begin
                        state_nxt = TRACK;
                        latch_off = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end
                end
                TRACK: begin
                    paddle_y_nxt = moved[8:0];
                    if (!ball_direction) state_nxt = CENTER;
                end
                default: state_nxt = CENTER;
            endcase
        end
    end

    // Stage boundary: state, hold counter and paddle position registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= CENTER;
            cnt_q    <= '0;
            paddle_y <= 9'(HOME_Y);
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            paddle_y <= paddle_y_nxt;
        end
    end

    assign state = state_q;

`ifdef AI_MISS_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= 8'hA5;
        end else if (frame_tick) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Offset is only consumed in TRACK, which is always entered through a latch.
    always_ff @(posedge clk) begin
        if (latch_off) offset <= $signed({6'b0, lfsr[4:0]}) - 11'sd16;
    end
`else
    logic unused_latch;
    assign offset       = '0;
    assign unused_latch = latch_off;
`endif

endmodule
